// File: rtl/mini_mips_pkg.sv
// Shared Mini-MIPS definitions: fetch-state encoding, default fetch constants
// and instruction field widths used by the fetch stage.
package mini_mips_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  // inst[25:0] is the J-type target index, inst[15:0] the I-type immediate
  localparam int unsigned JUMP_IDX_W = 26;
  localparam int unsigned IMM_W      = 16;

  function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: JR > J > taken branch > sequential.
module next_pc_logic
  import mini_mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [31:0]       inst,
  input  logic [31:0]       jr_target,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              branch,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;
  logic [31:0]       imm_ext;
  logic [5:0]        unused_opcode;

  assign unused_opcode = inst[31:26];

  // Narrow address spaces take the jump index alone; wide ones keep the upper pc_plus1 bits.
  generate
    if (ADDR_W > JUMP_IDX_W) begin : g_wide
      assign jump_target = {pc_plus1[ADDR_W-1:JUMP_IDX_W], inst[JUMP_IDX_W-1:0]};
    end else begin : g_narrow
      assign jump_target = inst[ADDR_W-1:0];
    end
  endgenerate

  assign imm_ext       = sext_imm(inst[IMM_W-1:0]);
  assign branch_target = pc_plus1 + imm_ext[ADDR_W-1:0];

  always_comb begin
    next_pc = pc_plus1;
    if (jump && jump_reg) begin
      next_pc = jr_target[ADDR_W-1:0];
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch && alu_zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Mini-MIPS fetch stage: PC, instruction-memory handshake and commit-time PC update.
// Optional halt-word detection is enabled by defining IFETCH_HALT_EN.
module instruction_fetch
  import mini_mips_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = DEF_RESET_PC[ADDR_W-1:0],
  parameter logic [31:0]       HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  input  logic              commit,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              branch,
  input  logic              alu_zero,
  input  logic [31:0]       jr_target,
  output logic              halted
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] next_pc;

  assign pc_plus1  = pc + ADDR_W'(1);
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  next_pc_logic #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_plus1  (pc_plus1),
    .inst      (inst),
    .jr_target (jr_target),
    .jump      (jump),
    .jump_reg  (jump_reg),
    .branch    (branch),
    .alu_zero  (alu_zero),
    .next_pc   (next_pc)
  );

`ifdef IFETCH_HALT_EN
  logic halted_q;

  assign halted = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (commit) begin
            inst_valid <= 1'b0;
            // A committed halt word freezes pc and stops all further requests
            if (inst == HALT_WORD) begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              pc    <= next_pc;
              state <= S_FETCH;
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  localparam logic [31:0] unused_halt_word = HALT_WORD;

  assign halted = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (commit) begin
            pc         <= next_pc;
            inst_valid <= 1'b0;
            state      <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule
